cir_if_block: RTL and testbench
===============================

Name: cir_if_block

Overview:
- Parameterised registered adder that groups operands `a`, `b` and result `c` behind one clocked interface.
- Each rising clock edge with valid input captures `a + b` into `c`, truncated to `WIDTH` bits.
- Also provides a carry-out, an optional saturation mode, an output-valid flag and a carry-event counter.
- Sits between a stimulus/control source and downstream logic that samples `c` one cycle after the operands are presented.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 1; benches also use 4).
- CNT_W, 16, width of the carry-event counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  operands valid this cycle.
- sat_en  input  1  1 = saturating add, 0 = wrap-around add.
- cnt_clr  input  1  synchronous clear of carry counter.
- c  output  WIDTH  registered result.
- carry  output  1  registered carry-out of the unsaturated sum.
- out_valid  output  1  `c`/`carry` hold a result produced from valid operands in the previous cycle.
- carry_cnt  output  CNT_W  number of accepted additions that produced a carry.

Behaviour:
- Reset:
  - One clock (`clk`); reset is asynchronous and active-high (`rst`).
  - While `rst` is high: `c`=0, `carry`=0, `out_valid`=0, `carry_cnt`=0, taking effect immediately without a clock edge.
  - Release is sampled on the next rising edge.
  - Reset mid-operation discards any in-flight result.
- Sum: form a WIDTH+1-bit sum `s` = zero-extended `a` + zero-extended `b`.
- Capture (posedge `clk`, `in_valid`=1):
  - `carry` <= s[WIDTH].
  - `sat_en`=0: `c` <= s[WIDTH-1:0], i.e. modulo 2^WIDTH wrap.
  - `sat_en`=1: `c` <= all-ones if s[WIDTH]=1, else s[WIDTH-1:0].
  - `out_valid` <= 1.
- Hold (posedge `clk`, `in_valid`=0):
  - `c` and `carry` hold their previous values.
  - `out_valid` <= 0.
- Latency: exactly one cycle. Operands applied before edge N are visible on `c` immediately after edge N and stable until edge N+1. No combinational path from inputs to outputs.
- Carry counter:
  - On an accepted add with s[WIDTH]=1, `carry_cnt` increments by 1.
  - `carry_cnt` saturates at 2^CNT_W−1 and does not wrap.
  - `cnt_clr`=1 forces `carry_cnt` <= 0 on the edge. If an increment occurs in the same cycle, clear wins.
  - `cnt_clr` does not affect `c`, `carry` or `out_valid`.
- Boundaries:
  - a=b=0 gives c=0, carry=0.
  - a=b=2^WIDTH−1 gives carry=1; c=2^WIDTH−2 when wrapping, 2^WIDTH−1 when saturating.
  - A sum exactly 2^WIDTH gives c=0 with carry=1 in wrap mode.
- Inputs are assumed stable around the rising edge. No X-propagation requirements beyond standard synthesis semantics.

Test Plan:
- Reset check: assert `rst` asynchronously mid-cycle after some adds -> `c`, `carry`, `out_valid`, `carry_cnt` are all 0 before the next edge; after release, the first valid add behaves normally.
- Wrap sweep (WIDTH=4, sat_en=0, in_valid=1): for i=0..9 drive a=i+1, b=i, sample 1 ns after each edge.
  - c = 1, 3, 5, 7, 9, 11, 13, 15, 1, 3.
  - carry = 1 only for the last two samples.
  - carry_cnt = 2 at the end.
- Saturation (WIDTH=4, sat_en=1): a=10, b=9 -> c=15, carry=1. Then a=7, b=8 -> c=15, carry=0.
- Default width (WIDTH=8): a=255, b=255, wrap -> c=254, carry=1. Then a=200, b=55 -> c=255, carry=0.
- Hold/valid: after a=3, b=4 captured (c=7), deassert in_valid and change a=9 -> c stays 7, out_valid=0 on the next edge; reasserting in_valid captures 13 with out_valid=1.
- Counter clear priority: with carry_cnt=2, drive a carrying add together with cnt_clr=1 -> carry_cnt=0. Next carrying add without clear -> carry_cnt=1.

Source files
------------

// File: rtl/cir_if_block.sv
// cir_if_block: registered a+b adder with carry-out, optional saturation, output-valid flag and saturating carry-event counter.
module cir_if_block #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             sat_en,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);
    logic [WIDTH:0] s;
    logic           cnt_inc;
    assign s = {1'b0, a} + {1'b0, b};
    assign cnt_inc = in_valid && s[WIDTH] && carry_cnt != '1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c         <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            carry_cnt <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                carry <= s[WIDTH];
                c     <= (sat_en && s[WIDTH]) ? '1 : s[WIDTH-1:0];
            end
            // clear takes priority over a same-cycle increment
            carry_cnt <= cnt_clr ? '0 : cnt_inc ? carry_cnt + CNT_W'(1) : carry_cnt;
        end
    end
endmodule

// File: tb/tb_cir_if_block.sv
// tb_cir_if_block: randomized and directed checks of 4-bit and 8-bit adder instances against an arithmetic reference model.
module tb_cir_if_block;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a4 = '0, b4 = '0, c4;
    logic [7:0] a8 = '0, b8 = '0, c8;
    logic       in_valid = 1'b0, sat_en = 1'b0, cnt_clr = 1'b0;
    logic       carry4, carry8, ov4, ov8;
    logic [2:0]  cnt4;
    logic [15:0] cnt8;
    int checks = 0, errors = 0;
    longint mc[2], mcar[2], mov[2], mcnt[2];

    cir_if_block #(.WIDTH(4), .CNT_W(3)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(in_valid), .sat_en(sat_en),
        .cnt_clr(cnt_clr), .c(c4), .carry(carry4), .out_valid(ov4), .carry_cnt(cnt4)
    );
    cir_if_block #(.WIDTH(8), .CNT_W(16)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid), .sat_en(sat_en),
        .cnt_clr(cnt_clr), .c(c8), .carry(carry8), .out_valid(ov8), .carry_cnt(cnt8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mc[k] = 0; mcar[k] = 0; mov[k] = 0; mcnt[k] = 0;
        end
    endtask

    task automatic check_all();
        chk("c4", c4, mc[0]);
        chk("carry4", carry4, mcar[0]);
        chk("ov4", ov4, mov[0]);
        chk("cnt4", cnt4, mcnt[0]);
        chk("c8", c8, mc[1]);
        chk("carry8", carry8, mcar[1]);
        chk("ov8", ov8, mov[1]);
        chk("cnt8", cnt8, mcnt[1]);
    endtask

    task automatic step(input int x4, input int y4, input int x8, input int y8,
                        input bit v, input bit sat, input bit clr);
        longint s, w, lim;
        a4 = 4'(x4); b4 = 4'(y4); a8 = 8'(x8); b8 = 8'(y8);
        in_valid = v; sat_en = sat; cnt_clr = clr;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            w   = k ? 8 : 4;
            lim = k ? 65535 : 7;
            s   = k ? longint'(x8 % 256) + longint'(y8 % 256) : longint'(x4 % 16) + longint'(y4 % 16);
            if (v) begin
                mcar[k] = s >= (64'd1 << w);
                mc[k]   = (sat && mcar[k] != 0) ? (64'd1 << w) - 1 : s % (64'd1 << w);
            end
            mov[k] = v;
            if (clr) mcnt[k] = 0;
            else if (v && s >= (64'd1 << w) && mcnt[k] < lim) mcnt[k]++;
        end
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 rst = 1'b0;

        // wrap sweep on the 4-bit instance
        for (int i = 0; i < 10; i++) begin
            step(i + 1, i, $urandom_range(0, 100), $urandom_range(0, 100), 1, 0, 0);
            chk("sweep_c", c4, (2 * i + 1) % 16);
            chk("sweep_carry", carry4, i >= 8);
        end
        chk("sweep_cnt", cnt4, 2);

        // clear wins over a same-cycle carry
        step(15, 1, 0, 0, 1, 0, 1);
        chk("clr_prio_cnt", cnt4, 0);
        step(15, 2, 0, 0, 1, 0, 0);
        chk("after_clr_cnt", cnt4, 1);

        // saturation and boundaries
        step(10, 9, 255, 255, 1, 1, 0);
        chk("sat_c4", c4, 15);
        chk("sat_c8", c8, 255);
        step(7, 8, 255, 255, 1, 0, 0);
        chk("sat_nc_c4", c4, 15);
        chk("sat_nc_carry4", carry4, 0);
        chk("wrap_c8", c8, 254);
        chk("wrap_carry8", carry8, 1);
        step(0, 0, 200, 55, 1, 0, 0);
        chk("zero_c4", c4, 0);
        chk("c8_255", c8, 255);
        chk("carry8_0", carry8, 0);
        step(8, 8, 128, 128, 1, 0, 0);
        chk("exact_c4", c4, 0);
        chk("exact_carry4", carry4, 1);

        // hold and valid
        step(3, 4, 1, 1, 1, 0, 0);
        chk("hold_pre", c4, 7);
        step(9, 4, 9, 9, 0, 0, 0);
        chk("hold_c", c4, 7);
        chk("hold_ov", ov4, 0);
        step(9, 4, 9, 9, 1, 0, 0);
        chk("resume_c", c4, 13);
        chk("resume_ov", ov4, 1);

        // counter saturation on the 3-bit counter
        for (int i = 0; i < 10; i++) step(15, 15, 1, 2, 1, 0, 0);
        chk("cnt_sat", cnt4, 7);

        // asynchronous reset mid-cycle
        a4 = 4'd5; b4 = 4'd6; in_valid = 1'b1;
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(2, 3, 20, 30, 1, 0, 0);
        chk("post_rst_c4", c4, 5);
        chk("post_rst_c8", c8, 50);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 15) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
